// File: rtl/lease_scheduler.sv
// Time-division lease scheduler: alternates fixed-length leases of one shared resource between two
// domains, each lease followed by a fixed scrub window. All outputs decode from registers only.
module lease_scheduler #(
    parameter int unsigned LEASE_W      = 8,
    parameter int unsigned SCRUB_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               cfg_we_i,
    input  logic [LEASE_W-1:0] cfg_len0_i,
    input  logic [LEASE_W-1:0] cfg_len1_i,
    output logic               grant0_o,
    output logic               grant1_o,
    output logic               owner_o,
    output logic [LEASE_W-1:0] remaining_o,
    output logic               expire_o,
    output logic               scrub_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {StIdle, StLease, StScrub} state_e;

    localparam logic [3:0] ScrubLast = 4'(SCRUB_CYCLES - 1);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [LEASE_W-1:0] cnt_q, cnt_d;
    logic [3:0]         scnt_q, scnt_d;
    logic [LEASE_W-1:0] pend0_q, pend0_d;
    logic [LEASE_W-1:0] pend1_q, pend1_d;

    logic               pick_valid;
    logic               pick_dom;
    logic [LEASE_W-1:0] pick_len;
    logic [LEASE_W-1:0] pend_other;
    logic [LEASE_W-1:0] pend_self;

    // Prefer the other domain, fall back to the current owner, else nobody.
    always_comb begin
        pend_other = owner_q ? pend0_q : pend1_q;
        pend_self  = owner_q ? pend1_q : pend0_q;
        pick_valid = 1'b1;
        pick_dom   = ~owner_q;
        if (pend_other != '0) begin
            pick_dom = ~owner_q;
        end else if (pend_self != '0) begin
            pick_dom = owner_q;
        end else begin
            pick_valid = 1'b0;
        end
        pick_len = pick_dom ? pend1_q : pend0_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        pend0_d = cfg_we_i ? cfg_len0_i : pend0_q;
        pend1_d = cfg_we_i ? cfg_len1_i : pend1_q;
        unique case (state_q)
            StIdle: begin
                if (en_i && pick_valid) begin
                    state_d = StLease;
                    owner_d = pick_dom;
                    cnt_d   = pick_len - LEASE_W'(1);
                end
            end
            StLease: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEASE_W'(1);
                end else begin
                    state_d = StScrub;
                    scnt_d  = ScrubLast;
                end
            end
            StScrub: begin
                if (scnt_q != 4'd0) begin
                    scnt_d = scnt_q - 4'd1;
                end else if (en_i && pick_valid) begin
                    state_d = StLease;
                    owner_d = pick_dom;
                    cnt_d   = pick_len - LEASE_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b1;
            cnt_q   <= '0;
            scnt_q  <= 4'd0;
            pend0_q <= '0;
            pend1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
        end
    end

    assign grant0_o    = (state_q == StLease) && !owner_q;
    assign grant1_o    = (state_q == StLease) && owner_q;
    assign owner_o     = owner_q;
    assign remaining_o = (state_q == StLease) ? cnt_q : '0;
    assign expire_o    = (state_q == StLease) && (cnt_q == '0);
    assign scrub_o     = (state_q == StScrub);
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_lease_scheduler.sv
// Scoreboard bench for lease_scheduler: stimulus queues per-cycle expected outputs, a monitor
// process compares them against the DUT on the falling edge.
module tb_lease_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_len0 = '0;
    logic [7:0] cfg_len1 = '0;
    logic       grant0, grant1, owner, expire, scrub, busy;
    logic [7:0] remaining;

    lease_scheduler #(
        .LEASE_W     (8),
        .SCRUB_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .cfg_we_i   (cfg_we),
        .cfg_len0_i (cfg_len0),
        .cfg_len1_i (cfg_len1),
        .grant0_o   (grant0),
        .grant1_o   (grant1),
        .owner_o    (owner),
        .remaining_o(remaining),
        .expire_o   (expire),
        .scrub_o    (scrub),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       g0;
        logic       g1;
        logic       own;
        logic [7:0] rem;
        logic       ex;
        logic       sc;
        logic       bz;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input int c, input logic g0, input logic g1, input logic own,
                        input int rem, input logic ex, input logic sc, input logic bz);
        exp_t e;
        e.cyc = c; e.g0 = g0; e.g1 = g1; e.own = own; e.rem = 8'(rem);
        e.ex = ex; e.sc = sc; e.bz = bz;
        q.push_back(e);
    endtask

    task automatic push_idle(input int c, input logic own);
        push(c, 1'b0, 1'b0, own, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_scrub(input int c, input logic own);
        push(c, 1'b0, 1'b0, own, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic push_grant(input int c, input logic dom, input int rem);
        push(c, ~dom, dom, dom, rem, (rem == 0), 1'b0, 1'b1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        en     = 1'b0;
        cfg_we = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: compare the head of the scoreboard when its cycle comes up.
    initial begin
        exp_t        e;
        logic [13:0] act, req;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                if (q[0].cyc == cyc) begin
                    e   = q.pop_front();
                    act = {grant0, grant1, owner, remaining, expire, scrub, busy};
                    req = {e.g0, e.g1, e.own, e.rem, e.ex, e.sc, e.bz};
                    n_vec++;
                    if (act !== req) begin
                        n_err++;
                        $display("FAIL cycle %0d outputs {g0,g1,own,rem,exp,scr,busy}: got %b_%b_%b_%0d_%b_%b_%b want %b_%b_%b_%0d_%b_%b_%b",
                                 cyc, grant0, grant1, owner, remaining, expire, scrub, busy,
                                 e.g0, e.g1, e.own, e.rem, e.ex, e.sc, e.bz);
                    end
                end else if (q[0].cyc < cyc) begin
                    e = q.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL cycle %0d missed check: got cycle %0d want cycle %0d",
                             e.cyc, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int s;
        int t;
        int ph;

        // Reset held for 5 cycles with all inputs low.
        repeat (5) tick();
        push_idle(cyc, 1'b1);
        push_idle(cyc + 1, 1'b1);
        reset = 1'b0;
        repeat (2) tick();

        // Basic alternation: len0=3, len1=2.
        do_reset();
        cfg_we = 1'b1; cfg_len0 = 8'd3; cfg_len1 = 8'd2;
        tick();
        cfg_we = 1'b0;
        s = cyc;
        en = 1'b1;
        push_idle(s, 1'b1);
        for (int i = 0; i < 3; i++) push_grant(s + 1 + i, 1'b0, 2 - i);
        push_scrub(s + 4, 1'b0);
        push_scrub(s + 5, 1'b0);
        push_grant(s + 6, 1'b1, 1);
        push_grant(s + 7, 1'b1, 0);
        push_scrub(s + 8, 1'b1);
        push_scrub(s + 9, 1'b1);
        push_grant(s + 10, 1'b0, 2);
        repeat (10) tick();

        // Skip: len0=4, len1=0 gives grant0 x4 then scrub x2, repeating.
        do_reset();
        cfg_we = 1'b1; cfg_len0 = 8'd4; cfg_len1 = 8'd0;
        tick();
        cfg_we = 1'b0;
        s = cyc;
        en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            ph = (k - 1) % 6;
            if (ph < 4) push_grant(s + k, 1'b0, 3 - ph);
            else        push_scrub(s + k, 1'b0);
        end
        repeat (13) tick();

        // Both lengths zero: stays idle; a write at a boundary only counts at the next one.
        do_reset();
        s = cyc;
        en = 1'b1;
        for (int k = 0; k < 4; k++) push_idle(s + k, 1'b1);
        repeat (3) tick();
        t = cyc;
        cfg_we = 1'b1; cfg_len0 = 8'd0; cfg_len1 = 8'd1;
        push_idle(t + 1, 1'b1);
        push_grant(t + 2, 1'b1, 0);
        push_scrub(t + 3, 1'b1);
        push_scrub(t + 4, 1'b1);
        push_grant(t + 5, 1'b1, 0);
        tick();
        cfg_we = 1'b0;
        repeat (4) tick();

        // Mid-lease reprogram and en drop do not disturb the running lease.
        do_reset();
        cfg_we = 1'b1; cfg_len0 = 8'd5; cfg_len1 = 8'd5;
        tick();
        cfg_we = 1'b0;
        s = cyc;
        en = 1'b1;
        for (int i = 0; i < 5; i++) push_grant(s + 1 + i, 1'b0, 4 - i);
        push_scrub(s + 6, 1'b0);
        push_scrub(s + 7, 1'b0);
        push_idle(s + 8, 1'b0);
        for (int i = 0; i < 5; i++) push_grant(s + 9 + i, 1'b1, 4 - i);
        push_scrub(s + 14, 1'b1);
        push_scrub(s + 15, 1'b1);
        push_grant(s + 16, 1'b0, 0);
        push_scrub(s + 17, 1'b0);
        push_scrub(s + 18, 1'b0);
        push_grant(s + 19, 1'b1, 4);
        repeat (2) tick();
        cfg_we = 1'b1; cfg_len0 = 8'd1; cfg_len1 = 8'd5;
        en = 1'b0;
        tick();
        cfg_we = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (11) tick();

        // Reset during the first grant1 cycle clears state and pending lengths.
        do_reset();
        cfg_we = 1'b1; cfg_len0 = 8'd1; cfg_len1 = 8'd8;
        tick();
        cfg_we = 1'b0;
        s = cyc;
        en = 1'b1;
        push_grant(s + 1, 1'b0, 0);
        push_scrub(s + 2, 1'b0);
        push_scrub(s + 3, 1'b0);
        push_grant(s + 4, 1'b1, 7);
        push_idle(s + 5, 1'b1);
        push_idle(s + 6, 1'b1);
        push_idle(s + 7, 1'b1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        repeat (3) tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL cycle %0d never checked: got none want check", e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
